// File: rtl/alu_sequencer.sv
// alu_sequencer: phase-based controller for the 4-bit ALU + accumulator datapath.
// Accepts {opcode, operand} instructions over a valid/ready handshake, runs a
// FETCH -> EXEC cycle per instruction, drives ALU select / accumulator / bus
// enables, latches Z/C flags and resolves jumps for the program counter.
// Optional feature macro: SEQ_SINGLE_STEP_EN (adds a step input and WAIT state).
module alu_sequencer #(
    parameter int         DATA_W  = 4,
    parameter logic [3:0] HALT_OP = 4'hF
) (
    input  logic                clk4,
    input  logic                reset4,
    input  logic [2*DATA_W-1:0] instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic                alu_z,
    input  logic                alu_c,
    output logic [2:0]          alu_sel,
    output logic                en_acu,
    output logic                en_bus_in,
    output logic                en_bus_out,
    output logic                pc_inc,
    output logic                pc_load,
    output logic [DATA_W-1:0]   jump_target,
    output logic                flag_z,
    output logic                flag_c,
    output logic                halted,
    input  logic                resume,
    output logic                illegal
`ifdef SEQ_SINGLE_STEP_EN
    ,
    input  logic                step
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [2*DATA_W-1:0] ir_reg;
    logic                flag_z_reg;
    logic                flag_c_reg;
    logic                illegal_reg;

    // Decode side-effects that land at the edge ending EXEC.
    logic                upd_flags;
    logic                undef_op;
    logic [3:0]          opcode;

    assign opcode      = ir_reg[2*DATA_W-1:DATA_W];
    assign jump_target = ir_reg[DATA_W-1:0];
    assign flag_z      = flag_z_reg;
    assign flag_c      = flag_c_reg;
    assign illegal     = illegal_reg;

    // State, instruction register, flags and sticky illegal flag.
    always_ff @(posedge clk4 or posedge reset4) begin
        if (reset4) begin
            state_reg   <= S_FETCH;
            ir_reg      <= '0;
            flag_z_reg  <= 1'b0;
            flag_c_reg  <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (pc_inc) begin
                ir_reg <= instr;
            end
            if (state_reg == S_EXEC) begin
                if (upd_flags) begin
                    flag_z_reg <= alu_z;
                    flag_c_reg <= alu_c;
                end
                if (undef_op) begin
                    illegal_reg <= 1'b1;
                end
            end
        end
    end

    // Next-state logic and per-phase control outputs; enables only live in EXEC.
    always_comb begin
        state_next  = state_reg;
        instr_ready = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        alu_sel     = 3'b000;
        en_acu      = 1'b0;
        en_bus_in   = 1'b0;
        en_bus_out  = 1'b0;
        halted      = 1'b0;
        upd_flags   = 1'b0;
        undef_op    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    pc_inc     = 1'b1;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opcode)
                    4'h1: begin alu_sel = 3'b010; en_bus_in = 1'b1; en_acu = 1'b1; end
                    4'h2: begin alu_sel = 3'b011; en_bus_in = 1'b1; en_acu = 1'b1; upd_flags = 1'b1; end
                    4'h3: begin alu_sel = 3'b001; en_bus_in = 1'b1; en_acu = 1'b1; upd_flags = 1'b1; end
                    4'h4: begin alu_sel = 3'b100; en_bus_in = 1'b1; en_acu = 1'b1; upd_flags = 1'b1; end
                    4'h5: begin alu_sel = 3'b001; en_bus_in = 1'b1; upd_flags = 1'b1; end
                    4'h6: en_bus_out = 1'b1;
                    // Conditional jumps look at flags latched by earlier instructions.
                    4'h7: pc_load = flag_c_reg;
                    4'h8: pc_load = ~flag_c_reg;
                    4'h9: pc_load = flag_z_reg;
                    4'hA: pc_load = ~flag_z_reg;
                    4'hB: pc_load = 1'b1;
                    4'hC, 4'hD, 4'hE: undef_op = 1'b1;
                    default: ;
                endcase
                if (opcode == HALT_OP) begin
                    state_next = S_HALT;
                end else begin
`ifdef SEQ_SINGLE_STEP_EN
                    state_next = S_WAIT;
`else
                    state_next = S_FETCH;
`endif
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume) begin
                    state_next = S_FETCH;
                end
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_WAIT: begin
                if (step) begin
                    state_next = S_FETCH;
                end
            end
`endif
            default: state_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer. The driver pushes the
// expected EXEC behaviour of every accepted instruction into a queue; a monitor
// pops and compares during EXEC and on the cycle after it. A small ALU +
// accumulator harness supplies alu_z/alu_c from the DUT's own controls.
module tb_alu_sequencer;

    logic       clk4 = 1'b0;
    logic       reset4;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic       alu_z;
    logic       alu_c;
    logic [2:0] alu_sel;
    logic       en_acu;
    logic       en_bus_in;
    logic       en_bus_out;
    logic       pc_inc;
    logic       pc_load;
    logic [3:0] jump_target;
    logic       flag_z;
    logic       flag_c;
    logic       halted;
    logic       resume;
    logic       illegal;

    alu_sequencer dut (
        .clk4        (clk4),
        .reset4      (reset4),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_z       (alu_z),
        .alu_c       (alu_c),
        .alu_sel     (alu_sel),
        .en_acu      (en_acu),
        .en_bus_in   (en_bus_in),
        .en_bus_out  (en_bus_out),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .jump_target (jump_target),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .halted      (halted),
        .resume      (resume),
        .illegal     (illegal)
    );

    always #5 clk4 = ~clk4;

    // ---------------- ALU + accumulator harness ----------------
    logic [3:0] h_acc;
    logic [3:0] h_r;
    logic       h_c;
    logic [4:0] h_wide;

    always_comb begin
        h_wide = 5'd0;
        h_r    = 4'd0;
        h_c    = 1'b0;
        case (alu_sel)
            3'b010: h_r = jump_target;
            3'b011: begin h_wide = {1'b0, h_acc} + {1'b0, jump_target}; h_r = h_wide[3:0]; h_c = h_wide[4]; end
            3'b001: begin h_wide = {1'b0, h_acc} + {1'b0, ~jump_target} + 5'd1; h_r = h_wide[3:0]; h_c = h_wide[4]; end
            3'b100: h_r = ~(h_acc & jump_target);
            default: ;
        endcase
        alu_z = (h_r == 4'd0);
        alu_c = h_c;
    end

    always @(posedge clk4 or posedge reset4) begin
        if (reset4) h_acc <= 4'd0;
        else if (en_acu) h_acc <= h_r;
    end

    // ---------------- scoreboard / reference model ----------------
    typedef struct {
        logic [7:0] ins;
        logic [2:0] sel;
        logic       acu;
        logic       bin;
        logic       bout;
        logic       pl;
        logic [3:0] jt;
        logic       fz;
        logic       fc;
        logic       ill;
        logic       hlt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_accept = 0;
    int   pc_inc_seen = 0;
    bit   sb_bypass = 0;

    int   m_acc = 0;
    bit   m_fz = 0;
    bit   m_fc = 0;
    bit   m_ill = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Instruction-level reference: what the datapath should see and where flags end up.
    function automatic exp_t model_step(input logic [7:0] ins);
        exp_t e;
        int   op;
        int   d;
        int   r;
        op = int'(ins[7:4]);
        d  = int'(ins[3:0]);
        e.ins = ins; e.sel = 3'd0; e.acu = 0; e.bin = 0; e.bout = 0; e.pl = 0;
        e.jt = ins[3:0]; e.hlt = 0;
        case (op)
            1: begin e.sel = 3'd2; e.acu = 1; e.bin = 1; m_acc = d; end
            2: begin e.sel = 3'd3; e.acu = 1; e.bin = 1; r = m_acc + d;
                     m_fc = (r > 15); m_acc = r % 16; m_fz = (m_acc == 0); end
            3: begin e.sel = 3'd1; e.acu = 1; e.bin = 1; m_fc = (m_acc >= d);
                     m_acc = (m_acc - d + 16) % 16; m_fz = (m_acc == 0); end
            4: begin e.sel = 3'd4; e.acu = 1; e.bin = 1; m_acc = 15 - (m_acc & d);
                     m_fz = (m_acc == 0); m_fc = 0; end
            5: begin e.sel = 3'd1; e.bin = 1; m_fz = (m_acc == d); m_fc = (m_acc >= d); end
            6: e.bout = 1;
            7: e.pl = m_fc;
            8: e.pl = !m_fc;
            9: e.pl = m_fz;
            10: e.pl = !m_fz;
            11: e.pl = 1;
            12, 13, 14: m_ill = 1;
            15: e.hlt = 1;
            default: ;
        endcase
        e.fz = m_fz; e.fc = m_fc; e.ill = m_ill;
        return e;
    endfunction

    // ---------------- monitor ----------------
    bit   pend_exec = 0;
    bit   pend_post = 0;
    exp_t cur;

    always @(negedge clk4) begin
        if (reset4) begin
            pend_exec = 0;
            pend_post = 0;
        end else begin
            if (pend_post) begin
                check("post_flag_z", flag_z, cur.fz);
                check("post_flag_c", flag_c, cur.fc);
                check("post_illegal", illegal, cur.ill);
                check("post_halted", halted, cur.hlt);
                check("post_alu_sel", alu_sel, 3'd0);
                check("post_enables", {en_acu, en_bus_in, en_bus_out, pc_load}, 4'd0);
                pend_post = 0;
            end
            if (pend_exec) begin
                pend_exec = 0;
                if (sb_q.size() == 0) begin
                    check("sb_nonempty", 8'd0, 8'd1);
                end else begin
                    cur = sb_q.pop_front();
                    check("exec_alu_sel", alu_sel, cur.sel);
                    check("exec_en_acu", en_acu, cur.acu);
                    check("exec_en_bus_in", en_bus_in, cur.bin);
                    check("exec_en_bus_out", en_bus_out, cur.bout);
                    check("exec_pc_load", pc_load, cur.pl);
                    check("exec_jump_target", jump_target, cur.jt);
                    check("exec_instr_ready", instr_ready, 1'b0);
                    $display("txn instr=%02h alu_sel=%0d en_acu=%0d en_bus_in=%0d en_bus_out=%0d pc_load=%0d",
                             cur.ins, alu_sel, en_acu, en_bus_in, en_bus_out, pc_load);
                    pend_post = 1;
                end
            end
            if (instr_valid && instr_ready && !sb_bypass) pend_exec = 1;
            if (pc_inc) pc_inc_seen++;
            if (pc_inc && pc_load) check("inc_load_exclusive", 8'd1, 8'd0);
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [7:0] x, input bit push);
        bit got;
        got = 0;
        instr = x;
        instr_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk4);
            if (instr_ready) got = 1;
        end
        if (!got) begin
            check("accept_timeout", 8'd0, 8'd1);
        end else begin
            n_accept++;
            if (push) sb_q.push_back(model_step(x));
        end
        @(posedge clk4);
        #1;
        instr_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        reset4 = 1'b1; instr = 8'h00; instr_valid = 1'b0; resume = 1'b0;
        repeat (2) @(posedge clk4);
        @(negedge clk4);
        reset4 = 1'b0;
        @(negedge clk4);
        check("rst_instr_ready", instr_ready, 1'b1);
        check("rst_alu_sel", alu_sel, 3'd0);
        check("rst_enables", {en_acu, en_bus_in, en_bus_out, pc_inc, pc_load}, 5'd0);
        check("rst_jump_target", jump_target, 4'd0);
        check("rst_flags", {flag_z, flag_c, illegal, halted}, 4'd0);
        @(posedge clk4); #1;

        // Directed sequences.
        issue(8'h15, 1); issue(8'h2C, 1);
        issue(8'h13, 1); issue(8'h53, 1);
        issue(8'h99, 1); issue(8'hA9, 1);
        issue(8'h63, 1); issue(8'hB7, 1);

        // HALT with fetch side holding valid high.
        issue(8'hF0, 1);
        instr = 8'h15; instr_valid = 1'b1;
        @(negedge clk4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk4);
            check("halt_halted", halted, 1'b1);
            check("halt_instr_ready", instr_ready, 1'b0);
        end
        @(posedge clk4); #1 resume = 1'b1;
        @(posedge clk4); #1 resume = 1'b0;
        issue(8'h15, 1);

        // Undefined opcode and sticky illegal.
        issue(8'hD0, 1); issue(8'h27, 1); issue(8'h6A, 1);

        // Randomised traffic (HALT excluded).
        for (int n = 0; n < 150; n++) begin
            r = 8'($urandom_range(0, 239));
            issue(r, 1);
        end

        // Asynchronous reset in the middle of an ADD EXEC.
        sb_bypass = 1;
        issue(8'h2C, 0);
        #2;
        check("pre_rst_en_acu", en_acu, 1'b1);
        reset4 = 1'b1;
        #1;
        check("midrst_en_acu", en_acu, 1'b0);
        check("midrst_alu_sel", alu_sel, 3'd0);
        check("midrst_flags", {flag_z, flag_c, illegal}, 3'd0);
        check("midrst_instr_ready", instr_ready, 1'b1);
        @(negedge clk4); #1;
        reset4 = 1'b0;
        m_acc = 0; m_fz = 0; m_fc = 0; m_ill = 0;
        sb_bypass = 0;
        @(posedge clk4); #1;
        check("postrst_instr_ready", instr_ready, 1'b1);
        check("postrst_flags", {flag_z, flag_c}, 2'd0);

        issue(8'h15, 1); issue(8'h2C, 1); issue(8'h55, 1);
        repeat (3) @(negedge clk4);
        check("pc_inc_count", 8'(pc_inc_seen), 8'(n_accept));
        check("sb_drained", 8'(sb_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
